// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register-file write path.
package regfile_pkg;

  localparam logic [3:0] REG_PC  = 4'hF;
  localparam int         NUM_GPR = 15;

  typedef enum logic {ARB_IDLE, ARB_CLEAR} wr_arb_state_t;

endpackage

// File: rtl/rr_priority_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_gnt && req[(int'(ptr) + k) % N]) begin
        any_gnt = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % N);
        gnt[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NREQ writeback sources and
// provides a zero-fill sequencer for R0..R(NGPR-1).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 4,
  parameter int NGPR = NUM_GPR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               clr_start,
  output logic               we3,
  output logic [AW-1:0]      wa3,
  output logic [DW-1:0]      wd3,
  output logic               clr_busy,
  output logic               clr_done,
  output logic               err_r15
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (NGPR > 1) ? $clog2(NGPR) : 1;

  wr_arb_state_t state, state_nxt;

  logic [PW-1:0]             rr_ptr;
  logic [CW-1:0]             clr_cnt;
  logic                      clr_last;
  logic [NREQ-1:0][AW-1:0]   addr_a;
  logic [NREQ-1:0][DW-1:0]   data_a;
  logic [NREQ-1:0]           gnt;
  logic [PW-1:0]             gnt_idx;
  logic                      any_gnt;
  logic                      arb_en;
  logic [AW-1:0]             gnt_addr;
  logic [DW-1:0]             gnt_data;

  assign addr_a   = req_addr;
  assign data_a   = req_data;
  assign gnt_addr = addr_a[gnt_idx];
  assign gnt_data = data_a[gnt_idx];
  assign clr_last = (clr_cnt == CW'(NGPR - 1));

  rr_priority_arbiter #(.N(NREQ), .IW(PW)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (clr_start) state_nxt = ARB_CLEAR;
      ARB_CLEAR: if (clr_last)  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // clr_start wins over requests; ready is also masked while reset is held.
  always_comb begin
    clr_busy  = (state == ARB_CLEAR);
    arb_en    = reset && (state == ARB_IDLE) && !clr_start;
    req_ready = arb_en ? gnt : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we3      <= 1'b0;
      wa3      <= '0;
      wd3      <= '0;
      clr_done <= 1'b0;
      err_r15  <= 1'b0;
      clr_cnt  <= '0;
      rr_ptr   <= '0;
    end else begin
      we3      <= 1'b0;
      clr_done <= 1'b0;
      err_r15  <= 1'b0;
      if (state == ARB_CLEAR) begin
        we3      <= 1'b1;
        wa3      <= AW'(clr_cnt);
        wd3      <= '0;
        clr_done <= clr_last;
        clr_cnt  <= clr_last ? '0 : clr_cnt + 1'b1;
      end else if (clr_start) begin
        clr_cnt <= '0;
      end else if (any_gnt) begin
        rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        // The PC slot is not writable from here; swallow it and flag.
        if (gnt_addr == AW'(REG_PC)) begin
          err_r15 <= 1'b1;
        end else begin
          we3 <= 1'b1;
          wa3 <= gnt_addr;
          wd3 <= gnt_data;
        end
      end
    end
  end

endmodule
